// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed neuron and its layer generator.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

  localparam int DW_DEFAULT = 8;
  localparam int DW_MAX     = 2**(DW_DEFAULT-1) - 1;
  localparam int DW_MIN     = -(2**(DW_DEFAULT-1));

  // Headroom for n full-width products plus a bias of the same scale.
  function automatic int acc_width(input int dw, input int n);
    return 2*dw + $clog2(n+1) + 1;
  endfunction

endpackage

// File: rtl/nn_act_quant.sv
// Accumulator to activation: round half up, ReLU (or leaky when NN_LEAKY_RELU_EN
// is defined), then saturate to DW bits.
module nn_act_quant
  import nn_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int ACC_W = acc_width(DW_DEFAULT, 15),
  parameter int SHIFT = 6
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [DW-1:0]    q
);

  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((2**(DW-1)) - 1);

  logic signed [ACC_W:0] acc_x;
  logic signed [ACC_W:0] r;

  // One extra bit so the rounding increment can never wrap the top value.
  assign acc_x = {acc[ACC_W-1], acc};
  assign r     = (acc_x >>> SHIFT) + {{ACC_W{1'b0}}, acc[SHIFT-1]};

`ifdef NN_LEAKY_RELU_EN
  localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-(2**(DW-1)));
  logic signed [ACC_W:0] r_leak;
  assign r_leak = r >>> 3;
`endif

  always_comb begin
    q = '0;
    if (acc[ACC_W-1]) begin
`ifdef NN_LEAKY_RELU_EN
      if (r_leak < Q_MIN) q = Q_MIN[DW-1:0];
      else                q = r_leak[DW-1:0];
`else
      q = '0;
`endif
    end else if (r > Q_MAX) begin
      q = Q_MAX[DW-1:0];
    end else begin
      q = r[DW-1:0];
    end
  end

endmodule

// File: rtl/nn_neuron_seq.sv
// Time-multiplexed neuron: one signed MAC walks N_IN inputs, then quantises.
// Build option NN_LEAKY_RELU_EN selects leaky ReLU in nn_act_quant.
module nn_neuron_seq
  import nn_pkg::*;
#(
  parameter  int N_IN  = 15,
  parameter  int DW    = DW_DEFAULT,
  parameter  int SHIFT = 6,
  localparam int ACC_W = acc_width(DW, N_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*DW-1:0]      in_data,
  input  logic [N_IN*DW-1:0]      weights,
  input  logic signed [ACC_W-1:0] bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int IDX_N = 2**IDX_W;

  state_t                  state_reg, state_next;
  logic [N_IN*DW-1:0]      a_reg, a_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    out_valid_next;
  logic [DW-1:0]           out_data_next;
  logic [DW-1:0]           quant;

  logic signed [DW-1:0]    a_arr [IDX_N];
  logic signed [DW-1:0]    w_arr [IDX_N];
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;

  // Padded to a power of two so every idx value selects a defined operand.
  generate
    for (genvar gi = 0; gi < IDX_N; gi++) begin : g_lane
      if (gi < N_IN) begin : g_used
        assign a_arr[gi] = a_reg[gi*DW +: DW];
        assign w_arr[gi] = weights[gi*DW +: DW];
      end else begin : g_pad
        assign a_arr[gi] = '0;
        assign w_arr[gi] = '0;
      end
    end
  endgenerate

  assign prod     = a_arr[idx_reg] * w_arr[idx_reg];
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

  nn_act_quant #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .acc (acc_reg),
    .q   (quant)
  );

  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    acc_next       = acc_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    in_ready       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_next     = in_data;
          acc_next   = bias;
          idx_next   = '0;
          state_next = MAC;
        end
      end
      MAC: begin
        acc_next = acc_reg + prod_ext;
        idx_next = idx_reg + 1'b1;
        if (idx_reg == IDX_W'(N_IN-1)) state_next = ACT;
      end
      ACT: begin
        out_data_next  = quant;
        out_valid_next = 1'b1;
        state_next     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
    end
  end

endmodule
